usb_txn_sequencer: RTL



---
 rtl/usb_txn_sequencer_pkg.sv | 30 +++
 rtl/usb_txn_sequencer_if.sv | 48 ++++
 rtl/usb_txn_sequencer_timer.sv | 43 ++++
 rtl/usb_txn_sequencer.sv | 192 +++++++++++++++++++
 4 files changed

// File: rtl/usb_txn_sequencer_pkg.sv
// -----------------------------------------------------------------------------
// USBPkg
// Shared definitions for the USB host transaction sequencer:
//   txn_state_t        - transaction FSM states
//   ENDP_ADDR/ENDP_DATA - endpoints used for the address and data phases
//   TIMEOUT_DEFAULT    - response wait, in cycles after a host packet ends
//   MAX_RETRY_DEFAULT  - retries per phase (a phase runs at most MAX_RETRY+1 times)
// -----------------------------------------------------------------------------
package USBPkg;

  typedef enum logic [3:0] {
    IDLE,
    A_TOK,
    A_DAT,
    A_HS,
    B_TOK,
    B_DAT,
    B_HS,
    B_RX,
    B_ACK,
    DONE
  } txn_state_t;

  localparam logic [3:0] ENDP_ADDR = 4'd4;
  localparam logic [3:0] ENDP_DATA = 4'd8;

  localparam int TIMEOUT_DEFAULT   = 255;
  localparam int MAX_RETRY_DEFAULT = 8;

endpackage

// File: rtl/usb_txn_sequencer_if.sv
// -----------------------------------------------------------------------------
// usb_txn_if
// Bundles the host task interface and the packet sender/receiver signals of
// the transaction sequencer.
//   slave  : the sequencer side (takes requests and rx events, drives strobes)
//   master : the host / PHY side
// Host side : start_read, start_write, mempage, wr_data -> busy, txn_done,
//             txn_success, rd_data
// PHY side  : send_OUT, send_IN, send_DATA0, send_ACK, endp, data ->
//             out_done, rx_ACK, rx_NAK, rx_DATA0, rx_data, rx_error
// -----------------------------------------------------------------------------
interface usb_txn_if;
  logic        start_read;
  logic        start_write;
  logic [15:0] mempage;
  logic [63:0] wr_data;
  logic        busy;
  logic        txn_done;
  logic        txn_success;
  logic [63:0] rd_data;

  logic        send_OUT;
  logic        send_IN;
  logic        send_DATA0;
  logic        send_ACK;
  logic [3:0]  endp;
  logic [63:0] data;
  logic        out_done;
  logic        rx_ACK;
  logic        rx_NAK;
  logic        rx_DATA0;
  logic [63:0] rx_data;
  logic        rx_error;

  modport slave (
    input  start_read, start_write, mempage, wr_data,
    output busy, txn_done, txn_success, rd_data,
    output send_OUT, send_IN, send_DATA0, send_ACK, endp, data,
    input  out_done, rx_ACK, rx_NAK, rx_DATA0, rx_data, rx_error
  );

  modport master (
    output start_read, start_write, mempage, wr_data,
    input  busy, txn_done, txn_success, rd_data,
    input  send_OUT, send_IN, send_DATA0, send_ACK, endp, data,
    output out_done, rx_ACK, rx_NAK, rx_DATA0, rx_data, rx_error
  );
endinterface

// File: rtl/usb_txn_sequencer_timer.sv
// -----------------------------------------------------------------------------
// usb_timeout_timer
// Response-wait counter shared by every wait state of the sequencer.
//   clock, reset : system clock, asynchronous active-high reset
//   clear_i      : force the count back to zero (held outside wait states)
//   en_i         : count one cycle of waiting
//   expired_o    : high while counting and the count has reached TIMEOUT
// -----------------------------------------------------------------------------
module usb_timeout_timer #(
  parameter int TIMEOUT = 255
) (
  input  logic clock,
  input  logic reset,
  input  logic clear_i,
  input  logic en_i,
  output logic expired_o
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);

  logic [CNT_W-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (clear_i) begin
      count_d = '0;
    end else if (en_i && (count_q != CNT_W'(TIMEOUT))) begin
      count_d = count_q + 1'b1;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  // The first wait cycle sees count 0, so expiry lands TIMEOUT cycles later.
  assign expired_o = en_i && (count_q == CNT_W'(TIMEOUT));

endmodule

// File: rtl/usb_txn_sequencer.sv
// -----------------------------------------------------------------------------
// usb_txn_sequencer
// Host-side controller that walks the USB packet sender through complete
// READ / WRITE page transactions:
//   phase A : OUT(ENDP_ADDR), DATA0({mempage,48'h0}), wait for handshake
//   phase B : write -> OUT(ENDP_DATA), DATA0(wr_data), wait for handshake
//             read  -> IN(ENDP_DATA), wait for DATA0, send ACK
// Ports:
//   clock, reset : system clock, asynchronous active-high reset
//   txn_if       : usb_txn_if.slave (host requests/status + PHY strobes/events)
// Configuration:
//   USB_TXN_RETRY_EN defined   - NAK / rx_error / timeout restart the phase,
//                                up to MAX_RETRY retries.
//   USB_TXN_RETRY_EN undefined - the first failure ends the transaction.
// -----------------------------------------------------------------------------
module usb_txn_sequencer
  import USBPkg::*;
#(
  parameter int TIMEOUT   = TIMEOUT_DEFAULT,
  parameter int MAX_RETRY = MAX_RETRY_DEFAULT
) (
  input logic      clock,
  input logic      reset,
  usb_txn_if.slave txn_if
);

`ifdef USB_TXN_RETRY_EN
  localparam bit RETRY_EN = 1'b1;
`else
  localparam bit RETRY_EN = 1'b0;
`endif

  localparam int RETRY_W = $clog2(MAX_RETRY + 2);

  txn_state_t       state_q, state_d;
  logic             first_q, first_d;     // first cycle in a state: strobe time
  logic             is_read_q, is_read_d;
  logic [15:0]      page_q, page_d;
  logic [63:0]      wdata_q, wdata_d;
  logic [RETRY_W-1:0] retry_q, retry_d;
  logic             success_q, success_d;
  logic [63:0]      hold_q, hold_d;       // read payload awaiting the final ACK
  logic [63:0]      rd_data_q, rd_data_d;

  logic wait_st;
  logic expired;
  logic fail;
  logic retry_left;

  assign wait_st = (state_q == A_HS) || (state_q == B_HS) || (state_q == B_RX);

  usb_timeout_timer #(
    .TIMEOUT (TIMEOUT)
  ) u_timer (
    .clock     (clock),
    .reset     (reset),
    .clear_i   (!wait_st),
    .en_i      (wait_st),
    .expired_o (expired)
  );

  // Without the retry feature this is constant 0, so the counter never
  // influences the FSM and drops out of the netlist.
  assign retry_left = RETRY_EN && (retry_q != RETRY_W'(MAX_RETRY));

  // NOTE: every always_comb output gets a default first, so no path through
  // the case statement can leave a signal unassigned and infer a latch.
  always_comb begin
    state_d   = state_q;
    is_read_d = is_read_q;
    page_d    = page_q;
    wdata_d   = wdata_q;
    retry_d   = retry_q;
    success_d = success_q;
    hold_d    = hold_q;
    rd_data_d = rd_data_q;
    fail      = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (txn_if.start_read || txn_if.start_write) begin
          is_read_d = txn_if.start_read;   // read wins a simultaneous request
          page_d    = txn_if.mempage;
          wdata_d   = txn_if.wr_data;
          success_d = 1'b0;
          retry_d   = '0;
          state_d   = A_TOK;
        end
      end
      A_TOK: if (txn_if.out_done) state_d = A_DAT;
      A_DAT: if (txn_if.out_done) state_d = A_HS;
      A_HS: begin
        if (txn_if.rx_ACK) begin
          retry_d = '0;
          state_d = B_TOK;
        end else if (txn_if.rx_NAK || txn_if.rx_error || txn_if.rx_DATA0 || expired) begin
          fail = 1'b1;
        end
      end
      B_TOK: if (txn_if.out_done) state_d = is_read_q ? B_RX : B_DAT;
      B_DAT: if (txn_if.out_done) state_d = B_HS;
      B_HS: begin
        if (txn_if.rx_ACK) begin
          success_d = 1'b1;
          state_d   = DONE;
        end else if (txn_if.rx_NAK || txn_if.rx_error || txn_if.rx_DATA0 || expired) begin
          fail = 1'b1;
        end
      end
      B_RX: begin
        if (txn_if.rx_DATA0) begin
          hold_d  = txn_if.rx_data;
          state_d = B_ACK;
        end else if (txn_if.rx_ACK || txn_if.rx_NAK || txn_if.rx_error || expired) begin
          // A handshake where data was expected is as bad as a corrupt packet.
          fail = 1'b1;
        end
      end
      B_ACK: begin
        if (txn_if.out_done) begin
          success_d = 1'b1;
          rd_data_d = hold_q;
          state_d   = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    if (fail) begin
      if (retry_left) begin
        retry_d = retry_q + 1'b1;
        state_d = (state_q == A_HS) ? A_TOK : B_TOK;
      end else begin
        state_d = DONE;
      end
    end

    // Every transition lands in a different state, so a change of state marks
    // the cycle in which the entered send state fires its strobe.
    first_d = (state_d != state_q);
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the values from before this edge, regardless of statement order.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      first_q   <= 1'b0;
      is_read_q <= 1'b0;
      page_q    <= '0;
      wdata_q   <= '0;
      retry_q   <= '0;
      success_q <= 1'b0;
      hold_q    <= '0;
      rd_data_q <= '0;
    end else begin
      state_q   <= state_d;
      first_q   <= first_d;
      is_read_q <= is_read_d;
      page_q    <= page_d;
      wdata_q   <= wdata_d;
      retry_q   <= retry_d;
      success_q <= success_d;
      hold_q    <= hold_d;
      rd_data_q <= rd_data_d;
    end
  end

  assign txn_if.busy        = (state_q != IDLE);
  assign txn_if.txn_done    = (state_q == DONE);
  assign txn_if.txn_success = success_q;
  assign txn_if.rd_data     = rd_data_q;

  assign txn_if.send_OUT   = first_q && ((state_q == A_TOK) || ((state_q == B_TOK) && !is_read_q));
  assign txn_if.send_IN    = first_q && (state_q == B_TOK) && is_read_q;
  assign txn_if.send_DATA0 = first_q && ((state_q == A_DAT) || (state_q == B_DAT));
  assign txn_if.send_ACK   = first_q && (state_q == B_ACK);

  always_comb begin
    txn_if.endp = 4'd0;
    txn_if.data = 64'd0;
    unique case (state_q)
      A_TOK:   txn_if.endp = ENDP_ADDR;
      B_TOK:   txn_if.endp = ENDP_DATA;
      A_DAT:   txn_if.data = {page_q, 48'h0};
      B_DAT:   txn_if.data = wdata_q;
      default: ;
    endcase
  end

endmodule
